// File: rtl/relogio_pkg.sv
// Shared constants for the clock core: field limits, FSM state encoding and
// the wrapping increment used by every time field.
package relogio_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'b00;
    localparam state_t ST_SET_HOUR = 2'b01;
    localparam state_t ST_SET_MIN  = 2'b10;

    // Values at or above the limit wrap to 0, so a corrupted field self-heals.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value >= max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge
// detector; one button press (however long) yields a single-cycle rise.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    // NOTE: sequential state uses non-blocking assignments so the three flops
    // shift as a chain instead of collapsing into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz prescaler, 24 h seconds/minutes/hours counters,
// button-driven set mode and the registered clk_15s strobe for the display.
module time_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] segundo,
    output logic [5:0] minuto,
    output logic [5:0] horas,
    output logic       clk_15s,
    output logic       tick_1hz,
    output logic [1:0] set_mode
);

    import relogio_pkg::*;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          mode_rise, inc_rise;
    logic          running;

    btn_sync_edge u_sync_mode (.clk(clk), .reset(reset), .din(btn_mode), .rise(mode_rise));
    btn_sync_edge u_sync_inc  (.clk(clk), .reset(reset), .din(btn_inc),  .rise(inc_rise));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (mode_rise) begin
            case (state)
                ST_RUN:      state_next = ST_SET_HOUR;
                ST_SET_HOUR: state_next = ST_SET_MIN;
                default:     state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        set_mode = state;
        running  = (state == ST_RUN);
    end

    assign tick_1hz = running && (presc == PRESC_LAST);

    // Held at 0 outside RUN, so leaving SET_MIN restarts a full second.
    always_ff @(posedge clk) begin
        if (reset || !running || tick_1hz) presc <= '0;
        else                               presc <= presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segundo <= 6'd0;
            minuto  <= 6'd0;
            horas   <= 6'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tick_1hz) begin
                        segundo <= wrap_inc(segundo, SEC_MAX);
                        if (segundo >= SEC_MAX) begin
                            minuto <= wrap_inc(minuto, MIN_MAX);
                            if (minuto >= MIN_MAX) horas <= wrap_inc(horas, HOUR_MAX);
                        end
                    end
                end
                ST_SET_HOUR: begin
                    if (inc_rise && !mode_rise) horas <= wrap_inc(horas, HOUR_MAX);
                end
                ST_SET_MIN: begin
                    if (mode_rise)     segundo <= 6'd0;
                    else if (inc_rise) minuto  <= wrap_inc(minuto, MIN_MAX);
                end
                default: ;
            endcase
        end
    end

    // Quarter-minute strobe for the display multiplexer, one cycle behind segundo.
    always_ff @(posedge clk) begin
        if (reset) clk_15s <= 1'b0;
        else       clk_15s <= running && (segundo == 6'd0 || segundo == 6'd15 ||
                                          segundo == 6'd30 || segundo == 6'd45);
    end

endmodule
